// File: rtl/scale_pkg.sv
// Shared types and widths for the scale_demux 1-to-2 stream demultiplexer.
package scale_pkg;

    localparam int unsigned SCALE_CNT_W = 16;

    typedef enum logic {ROUTE_B, ROUTE_A} route_t;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice with valid/ready handshake.
// Optional delivered-beat counter when SCALE_DEMUX_COUNT_EN is defined.
module demux_slot
    import scale_pkg::*;
#(
    parameter int unsigned size = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [size-1:0]        in_data,
    input  logic                   ready,
    output logic                   can_load,
    output logic                   valid,
    output logic [size-1:0]        data
`ifdef SCALE_DEMUX_COUNT_EN
    ,
    output logic [SCALE_CNT_W-1:0] cnt
`endif
);

    slot_state_t state;

    assign valid    = (state == SLOT_FULL);
    // A full slot can still load when its consumer drains on the same edge.
    assign can_load = (state == SLOT_EMPTY) || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        data  <= in_data;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        data <= in_data;
                    end else if (ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

`ifdef SCALE_DEMUX_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/scale_demux.sv
// Registered 1-to-2 demultiplexer: routes each input beat to output A or B.
// Define SCALE_DEMUX_COUNT_EN to add the cnt_a/cnt_b delivered-beat counters.
module scale_demux
    import scale_pkg::*;
#(
    parameter int unsigned size = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [size-1:0]        in_data,
    input  logic                   in_valid,
    input  logic                   sel_a,
    output logic                   in_ready,
    output logic [size-1:0]        out_a_data,
    output logic                   out_a_valid,
    input  logic                   out_a_ready,
    output logic [size-1:0]        out_b_data,
    output logic                   out_b_valid,
    input  logic                   out_b_ready
`ifdef SCALE_DEMUX_COUNT_EN
    ,
    output logic [SCALE_CNT_W-1:0] cnt_a,
    output logic [SCALE_CNT_W-1:0] cnt_b
`endif
);

    route_t route;
    logic   can_load_a;
    logic   can_load_b;
    logic   load_a;
    logic   load_b;

    assign route    = route_t'(sel_a);
    // Readiness follows the selected slot only, so a stalled consumer never blocks the other.
    assign in_ready = (route == ROUTE_A) ? can_load_a : can_load_b;
    assign load_a   = in_valid && in_ready && (route == ROUTE_A);
    assign load_b   = in_valid && in_ready && (route == ROUTE_B);

    demux_slot #(.size(size)) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .load     (load_a),
        .in_data  (in_data),
        .ready    (out_a_ready),
        .can_load (can_load_a),
        .valid    (out_a_valid),
        .data     (out_a_data)
`ifdef SCALE_DEMUX_COUNT_EN
        ,
        .cnt      (cnt_a)
`endif
    );

    demux_slot #(.size(size)) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .load     (load_b),
        .in_data  (in_data),
        .ready    (out_b_ready),
        .can_load (can_load_b),
        .valid    (out_b_valid),
        .data     (out_b_data)
`ifdef SCALE_DEMUX_COUNT_EN
        ,
        .cnt      (cnt_b)
`endif
    );

endmodule

// File: tb/tb_scale_demux.sv
// Self-checking bench for scale_demux (size=8): directed vector table,
// async-reset corner case, and randomized traffic against a queue model.
module tb_scale_demux;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       sel_a;
    logic       in_ready;
    logic [7:0] out_a_data;
    logic       out_a_valid;
    logic       out_a_ready;
    logic [7:0] out_b_data;
    logic       out_b_valid;
    logic       out_b_ready;
`ifdef SCALE_DEMUX_COUNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    scale_demux #(.size(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .sel_a       (sel_a),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready)
`ifdef SCALE_DEMUX_COUNT_EN
        ,
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic iv, input logic sel, input logic [7:0] d,
                         input logic ra, input logic rb);
        in_valid    = iv;
        sel_a       = sel;
        in_data     = d;
        out_a_ready = ra;
        out_b_ready = rb;
    endtask

    // Reference model: each output is a FIFO of at most one beat.
    logic [7:0]  a_q[$];
    logic [7:0]  b_q[$];
    int unsigned n_a;
    int unsigned n_b;

    function automatic logic model_ready();
        if (sel_a) return (a_q.size() == 0) || out_a_ready;
        return (b_q.size() == 0) || out_b_ready;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_va"}, 32'(out_a_valid), 32'(a_q.size() != 0));
        chk({tag, "_vb"}, 32'(out_b_valid), 32'(b_q.size() != 0));
        chk({tag, "_rdy"}, 32'(in_ready), 32'(model_ready()));
        if (a_q.size() != 0) chk({tag, "_da"}, 32'(out_a_data), 32'(a_q[0]));
        if (b_q.size() != 0) chk({tag, "_db"}, 32'(out_b_data), 32'(b_q[0]));
    endtask

    task automatic model_update();
        logic acc;
        acc = in_valid && model_ready();
        if (a_q.size() != 0 && out_a_ready) begin void'(a_q.pop_front()); n_a++; end
        if (b_q.size() != 0 && out_b_ready) begin void'(b_q.pop_front()); n_b++; end
        if (acc) begin
            if (sel_a) a_q.push_back(in_data);
            else       b_q.push_back(in_data);
        end
    endtask

    typedef struct {
        logic       iv;
        logic       sel;
        logic [7:0] d;
        logic       ra;
        logic       rb;
        logic       eva;
        logic [7:0] eda;
        logic       evb;
        logic [7:0] edb;
        logic       erdy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Expected outputs are those seen before the edge that applies the inputs.
        vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h77, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 8'h77, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 8'h77, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};

        n_a = 0;
        n_b = 0;

        // Reset with a valid beat presented: slots empty, in_ready reflects empty slot.
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        #1;
        chk("rst_va", 32'(out_a_valid), 32'd0);
        chk("rst_vb", 32'(out_b_valid), 32'd0);
        chk("rst_da", 32'(out_a_data), 32'd0);
        chk("rst_db", 32'(out_b_data), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
`ifdef SCALE_DEMUX_COUNT_EN
        chk("rst_cnta", 32'(cnt_a), 32'd0);
        chk("rst_cntb", 32'(cnt_b), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].ra, vecs[i].rb);
            #1;
            chk($sformatf("vec%0d_va", i), 32'(out_a_valid), 32'(vecs[i].eva));
            chk($sformatf("vec%0d_vb", i), 32'(out_b_valid), 32'(vecs[i].evb));
            chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(vecs[i].erdy));
            if (vecs[i].eva) chk($sformatf("vec%0d_da", i), 32'(out_a_data), 32'(vecs[i].eda));
            if (vecs[i].evb) chk($sformatf("vec%0d_db", i), 32'(out_b_data), 32'(vecs[i].edb));
            @(posedge clk);
            @(negedge clk);
        end

        // Fill both slots, then assert reset between edges.
        drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("full_va", 32'(out_a_valid), 32'd1);
        chk("full_vb", 32'(out_b_valid), 32'd1);
        chk("full_da", 32'(out_a_data), 32'h5A);
        chk("full_db", 32'(out_b_data), 32'hC3);
        #1 rst = 1'b1;
        #1;
        chk("arst_va", 32'(out_a_valid), 32'd0);
        chk("arst_vb", 32'(out_b_valid), 32'd0);
        chk("arst_da", 32'(out_a_data), 32'd0);
        chk("arst_db", 32'(out_b_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic honouring the producer stability rule.
        begin
            logic hold;
            hold = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (!hold) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    sel_a    = 1'($urandom_range(0, 1));
                    in_data  = 8'($urandom);
                end
                out_a_ready = ($urandom_range(0, 3) != 0);
                out_b_ready = ($urandom_range(0, 2) != 0);
                #1;
                check_model($sformatf("rnd%0d", c));
                hold = in_valid && !model_ready();
                model_update();
                @(posedge clk);
                @(negedge clk);
            end
        end
`ifdef SCALE_DEMUX_COUNT_EN
        chk("rnd_cnta", 32'(cnt_a), 32'(n_a[15:0]));
        chk("rnd_cntb", 32'(cnt_b), 32'(n_b[15:0]));

        // Counter wrap: 65537 deliveries on A.
        rst = 1'b1;
        #1 rst = 1'b0;
        drive(1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
        for (int c = 0; c < 65537; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("wrap_cnta", 32'(cnt_a), 32'd1);
        chk("wrap_cntb", 32'(cnt_b), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/scale_demux.md
# scale_demux

Registered 1-to-2 demultiplexer with valid/ready handshaking: a single input stream is routed, beat by beat, to output A or output B according to `sel_a`. It is the fan-out counterpart to the lab's 2-to-1 width-parameterized multiplexor and sits where one producer feeds two independent consumers. Each output has its own one-entry holding register, so a stalled consumer never blocks traffic bound for the other output once that beat has been accepted.

## Interface
- `size`, default 1: data width in bits for `in_data`, `out_a_data` and `out_b_data`.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_data`  input  size: input beat.
- `in_valid`  input  1: `in_data` and `sel_a` are valid.
- `sel_a`  input  1: route select; 1'b1 sends the beat to A, 1'b0 sends it to B. Sampled only when `in_valid` is high.
- `in_ready`  output  1: a beat is accepted when `in_valid && in_ready`.
- `out_a_data`  output  size: output A data.
- `out_a_valid`  output  1: output A holds a beat.
- `out_a_ready`  input  1: consumer A accepts the beat.
- `out_b_data`  output  size: output B data.
- `out_b_valid`  output  1: output B holds a beat.
- `out_b_ready`  input  1: consumer B accepts the beat.
- `cnt_a`  output  16: beats delivered on A. Present only with `SCALE_DEMUX_COUNT_EN`.
- `cnt_b`  output  16: beats delivered on B. Present only with `SCALE_DEMUX_COUNT_EN`.

## Operation
- Each output has one slot with two states, EMPTY and FULL. `out_x_valid` is 1 exactly when slot x is FULL.
- Slot can load: slot is EMPTY, or slot is FULL and `out_x_ready` is high in the same cycle (drain).
- `in_ready` is the can-load signal of the slot selected by the current `sel_a`. It depends combinationally on `sel_a` and the selected `out_x_ready`, and is independent of `in_valid`.
- Slot transitions:
  - EMPTY + load goes to FULL.
  - FULL + drain with no load goes to EMPTY.
  - FULL + drain + load stays FULL and takes the new data.
  - FULL with no drain holds; data stays stable.
- The non-selected slot is unaffected by input activity. Both slots may drain in the same cycle.
- Producer rule: `in_data` and `sel_a` must stay stable while `in_valid && !in_ready`. The block does not check this.
- Consumer rule: `out_x_data` never changes while `out_x_valid && !out_x_ready`.
- Beats routed to the same output are delivered in order. No ordering holds between A and B.
- Reset values: both slots EMPTY; `out_a_valid`, `out_b_valid`, `out_a_data`, `out_b_data` all 0; counters 0.
- Reset asserted mid-operation: held beats are discarded and the valids drop immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `out_x_valid`/`out_x_data` after edge N.
- Throughput is 1 beat per cycle per output when the consumer holds `out_x_ready` high.
- Full-plus-drain pass-through: accept and drain on the same edge; the new beat is visible the next cycle with no bubble.
- A stalled output stalls only inputs selecting it. `in_ready` goes low only when the selected slot is FULL and its ready is low.

## Configuration
- `SCALE_DEMUX_COUNT_EN` defined:
  - `cnt_a` and `cnt_b` ports exist.
  - Each counter increments on its output's `valid && ready`.
  - Counters wrap from 16'hFFFF to 0 and are cleared by `rst`.
- Macro undefined: the counter ports and logic are absent. Routing behaviour is identical.

## Structure
- Package `scale_pkg` holds:
  - `SCALE_CNT_W` = 16.
  - `typedef enum logic {ROUTE_B, ROUTE_A} route_t`.
  - `typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t`.
- Sub-module `demux_slot` is a one-entry register slice (load/drain/valid/data) with optional counter, instantiated twice. The top level holds only routing and `in_ready` logic.

## Test plan
- Reset with `in_valid`=1 asserted: both valids are 0 and `in_ready` reflects an EMPTY slot (1).
- `size`=8; send 8'hA5 with `sel_a`=1 and 8'h3C with `sel_a`=0 back to back, both readies high: A shows A5 after cycle 1, B shows 3C after cycle 2.
- Hold `out_a_ready`=0, send two beats to A: second beat sees `in_ready`=0 and is held; 8'h11 on `out_a_data` stays stable. Meanwhile a beat to B is accepted.
- A FULL with `out_a_ready`=1 and a new A beat on the same edge: new data is visible next cycle; `out_a_valid` stays 1 with no gap.
- Assert `rst` asynchronously while both slots are FULL: both valids are 0 before the next `clk` edge.
- With `SCALE_DEMUX_COUNT_EN`: 65537 beats to A give `cnt_a`=1 (wrap), `cnt_b`=0.
